// File: rtl/chnl_arbiter_if.sv
// Channel-arbiter bus: slack/config inputs, formatter handshake and FIFO read strobes.
// Latency: none (wires only).
// Backpressure: formatter holds off a packet by keeping fmt_grant low while fmt_req is high.
interface chnl_arbiter_if #(
  parameter int PTR_WIDE = 3
);
  logic [PTR_WIDE:0] ch_slack0;
  logic [PTR_WIDE:0] ch_slack1;
  logic [PTR_WIDE:0] ch_slack2;
  logic [2:0]        ch_en;
  logic [1:0]        ch_prio0;
  logic [1:0]        ch_prio1;
  logic [1:0]        ch_prio2;
  logic [1:0]        pkt_len;
  logic              fmt_grant;
  logic [2:0]        ch_rd_en;
  logic              fmt_req;
  logic [1:0]        fmt_chid;
  logic [3:0]        fmt_length;
  logic              fmt_send;
  logic              fmt_start;
  logic              fmt_end;
  logic              arb_busy;

  // Arbiter side
  modport master (
    input  ch_slack0, ch_slack1, ch_slack2, ch_en, ch_prio0, ch_prio1, ch_prio2,
           pkt_len, fmt_grant,
    output ch_rd_en, fmt_req, fmt_chid, fmt_length, fmt_send, fmt_start, fmt_end,
           arb_busy
  );

  // Channel FIFOs / formatter side
  modport slave (
    output ch_slack0, ch_slack1, ch_slack2, ch_en, ch_prio0, ch_prio1, ch_prio2,
           pkt_len, fmt_grant,
    input  ch_rd_en, fmt_req, fmt_chid, fmt_length, fmt_send, fmt_start, fmt_end,
           arb_busy
  );
endinterface

// File: rtl/chnl_arbiter.sv
// Packet arbiter: picks a channel holding a full packet (priority, round-robin ties) and bursts its reads.
// Latency: fmt_req one cycle after eligibility; first read the cycle after fmt_grant; L reads back to back.
// Backpressure: waits in REQ with no reads while fmt_grant is low; config changes apply only from IDLE.
module chnl_arbiter #(
  parameter int PTR_WIDE = 3,
  parameter int MAX_CNT  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  chnl_arbiter_if.master bus
);

  // Occupancy math runs at least 4 bits wide so packet lengths up to 8 compare cleanly.
  localparam int CW = (PTR_WIDE + 1 > 4) ? PTR_WIDE + 1 : 4;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SEND} state_t;

  state_t      state, state_nxt;
  logic [3:0]  word_cnt;
  logic [1:0]  last_ch;
  logic [1:0]  chid_q;
  logic [3:0]  len_q;
  logic        req_q;
  logic        busy_q;
  logic [3:0]  sel_len;
  logic [2:0]  elig;
  logic [1:0]  prio [3];
  logic        win_vld;
  logic [1:0]  win_ch;
  logic [1:0]  best_prio;
  logic [1:0]  rr_ch;
  logic        last_word;

  // Free entries above the FIFO depth mean "empty", never a negative occupancy.
  function automatic logic [CW-1:0] occ_of(input logic [PTR_WIDE:0] slack);
    logic [CW-1:0] s;
    logic [CW-1:0] m;
    s = CW'(slack);
    m = CW'(MAX_CNT);
    return (s > m) ? '0 : m - s;
  endfunction

  // k-th candidate in round-robin order, starting just after the last served channel.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off} + 3'd1;
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  assign sel_len = 4'd1 << bus.pkt_len;
  assign prio[0] = bus.ch_prio0;
  assign prio[1] = bus.ch_prio1;
  assign prio[2] = bus.ch_prio2;

  assign elig[0] = bus.ch_en[0] && (occ_of(bus.ch_slack0) >= CW'(sel_len));
  assign elig[1] = bus.ch_en[1] && (occ_of(bus.ch_slack1) >= CW'(sel_len));
  assign elig[2] = bus.ch_en[2] && (occ_of(bus.ch_slack2) >= CW'(sel_len));

  assign last_word = (word_cnt == len_q - 4'd1);

  assign bus.fmt_req    = req_q;
  assign bus.arb_busy   = busy_q;
  assign bus.fmt_chid   = chid_q;
  assign bus.fmt_length = len_q;

  // Winner: scan in round-robin order and keep the first channel with strictly lower priority value.
  always_comb begin
    win_vld   = 1'b0;
    win_ch    = 2'd0;
    best_prio = 2'd3;
    rr_ch     = 2'd0;
    for (int k = 0; k < 3; k++) begin
      rr_ch = rr_idx(last_ch, 2'(k));
      if (elig[rr_ch] && (!win_vld || prio[rr_ch] < best_prio)) begin
        win_vld   = 1'b1;
        win_ch    = rr_ch;
        best_prio = prio[rr_ch];
      end
    end
  end

  // State register; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state plus the read strobes, which decode straight from state and word counter.
  always_comb begin
    state_nxt     = state;
    bus.ch_rd_en  = 3'b000;
    bus.fmt_send  = 1'b0;
    bus.fmt_start = 1'b0;
    bus.fmt_end   = 1'b0;
    case (state)
      S_IDLE: if (win_vld) state_nxt = S_REQ;
      S_REQ:  if (bus.fmt_grant) state_nxt = S_SEND;
      S_SEND: begin
        bus.ch_rd_en  = 3'b001 << chid_q;
        bus.fmt_send  = 1'b1;
        bus.fmt_start = (word_cnt == 4'd0);
        bus.fmt_end   = last_word;
        if (last_word) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Packet descriptor latched at selection, word counter, round-robin pointer and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= 4'd0;
      last_ch  <= 2'd2;
      chid_q   <= 2'd0;
      len_q    <= 4'd0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      req_q  <= (state_nxt == S_REQ);
      busy_q <= (state_nxt != S_IDLE);
      if (state == S_IDLE && win_vld) begin
        chid_q <= win_ch;
        len_q  <= sel_len;
      end
      if (state == S_REQ && bus.fmt_grant) word_cnt <= 4'd0;
      else if (state == S_SEND)            word_cnt <= last_word ? 4'd0 : word_cnt + 4'd1;
      if (state == S_SEND && last_word) last_ch <= chid_q;
    end
  end

endmodule

// File: tb/tb_chnl_arbiter.sv
// Bench for chnl_arbiter: directed scenarios plus random traffic against a packet-timeline model.
// Latency: outputs checked every cycle on the falling edge.
// Backpressure: fmt_grant driven low/high/random to exercise REQ stalls.
module tb_chnl_arbiter;
  localparam int MAX_CNT = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  chnl_arbiter_if #(.PTR_WIDE(3)) bus ();

  chnl_arbiter #(.PTR_WIDE(3), .MAX_CNT(MAX_CNT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Environment: FIFO fill levels and configuration
  int         cnt [3];
  logic [2:0] cfg_en;
  logic [1:0] cfg_prio [3];
  logic [1:0] cfg_len;
  int         grant_mode;   // 0 low, 1 high, 2 random
  int         ovr0;         // nonzero: force ch_slack0 to this value
  int         wr_pct;

  // Packet-timeline model: phase 0 idle, 1 requesting, 2 reading
  int m_phase, m_ch, m_len, m_last, m_g, m_cyc;

  // Observations for directed checks
  int served[$];
  int rd_cnt [3];
  int req_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int slack_of(input int i);
    if (i == 0 && ovr0 != 0) return ovr0;
    return MAX_CNT - cnt[i];
  endfunction

  function automatic int occ_of(input int i);
    int s;
    s = slack_of(i);
    return (s > MAX_CNT) ? 0 : MAX_CNT - s;
  endfunction

  // Lowest (priority, distance after last served) among channels holding a full packet.
  function automatic int pick();
    int best, best_key, key;
    best = -1;
    best_key = 1000;
    for (int i = 0; i < 3; i++) begin
      if (cfg_en[i] && occ_of(i) >= (1 << cfg_len)) begin
        key = int'(cfg_prio[i]) * 3 + ((i - m_last + 2) % 3);
        if (key < best_key) begin
          best_key = key;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic clear_obs();
    served.delete();
    for (int i = 0; i < 3; i++) rd_cnt[i] = 0;
    req_cnt = 0;
  endtask

  task automatic apply_inputs();
    bus.ch_slack0 = 4'(slack_of(0));
    bus.ch_slack1 = 4'(slack_of(1));
    bus.ch_slack2 = 4'(slack_of(2));
    bus.ch_en     = cfg_en;
    bus.ch_prio0  = cfg_prio[0];
    bus.ch_prio1  = cfg_prio[1];
    bus.ch_prio2  = cfg_prio[2];
    bus.pkt_len   = cfg_len;
    case (grant_mode)
      0:       bus.fmt_grant = 1'b0;
      1:       bus.fmt_grant = 1'b1;
      default: bus.fmt_grant = 1'($urandom_range(1));
    endcase
  endtask

  task automatic check_cycle();
    logic [7:0] e;
    int idx;
    e = '0;
    if (m_phase == 2) begin
      idx = m_cyc - m_g;
      e[7:5] = 3'(1 << m_ch);
      e[3] = 1'b1;
      e[2] = (idx == 0);
      e[1] = (idx == m_len - 1);
      e[0] = 1'b1;
    end else if (m_phase == 1) begin
      e[4] = 1'b1;
      e[0] = 1'b1;
    end
    chk("outs{rd,req,send,start,end,busy}",
        {bus.ch_rd_en, bus.fmt_req, bus.fmt_send, bus.fmt_start, bus.fmt_end, bus.arb_busy}, e);
    if (m_phase != 0) begin
      chk("fmt_chid", bus.fmt_chid, m_ch);
      chk("fmt_length", bus.fmt_length, m_len);
    end
    if (bus.fmt_start) served.push_back(int'(bus.fmt_chid));
    for (int i = 0; i < 3; i++) rd_cnt[i] += int'(bus.ch_rd_en[i]);
    req_cnt += int'(bus.fmt_req);
  endtask

  task automatic drive_advance();
    if (m_phase == 2) begin
      chk("no_overread", cnt[m_ch] > 0, 1);
      if (cnt[m_ch] > 0) cnt[m_ch]--;
    end
    for (int i = 0; i < 3; i++)
      if (cnt[i] < MAX_CNT && $urandom_range(99) < wr_pct) cnt[i]++;
    apply_inputs();
    m_cyc++;
    if (rst_n) begin
      case (m_phase)
        1: if (bus.fmt_grant) begin
             m_phase = 2;
             m_g = m_cyc;
           end
        2: if (m_cyc == m_g + m_len) begin
             m_phase = 0;
             m_last = m_ch;
           end
        default: begin
          int w;
          w = pick();
          if (w >= 0) begin
            m_phase = 1;
            m_ch = w;
            m_len = 1 << cfg_len;
          end
        end
      endcase
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    drive_advance();
  endtask

  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    #1;
    chk("rst_zero", {bus.ch_rd_en, bus.fmt_req, bus.fmt_chid, bus.fmt_length, bus.fmt_send,
                     bus.fmt_start, bus.fmt_end, bus.arb_busy}, 0);
    m_phase = 0;
    m_last = 2;
    repeat (ncyc) @(negedge clk);
    rst_n = 1'b1;
    drive_advance();
  endtask

  task automatic set_cfg(input logic [2:0] en, input int p0, input int p1, input int p2,
                         input int len, input int c0, input int c1, input int c2);
    cfg_en = en;
    cfg_prio[0] = 2'(p0);
    cfg_prio[1] = 2'(p1);
    cfg_prio[2] = 2'(p2);
    cfg_len = 2'(len);
    cnt[0] = c0;
    cnt[1] = c1;
    cnt[2] = c2;
  endtask

  int rr_exp [4] = '{0, 1, 2, 0};
  int pr_exp [5] = '{2, 2, 2, 2, 0};
  bit found;

  initial begin
    m_phase = 0; m_last = 2; m_cyc = 0; m_ch = 0; m_len = 0; m_g = 0;
    grant_mode = 1; ovr0 = 0; wr_pct = 0;
    set_cfg(3'b111, 0, 0, 0, 0, 8, 8, 8);
    clear_obs();
    rst_n = 1'b1;
    apply_inputs();
    #2;
    // Reset values with all FIFOs full, then first request goes to ch0
    rst_n = 1'b0;
    #1;
    chk("rst_outs", {bus.ch_rd_en, bus.fmt_req, bus.fmt_chid, bus.fmt_length, bus.fmt_send,
                     bus.fmt_start, bus.fmt_end, bus.arb_busy}, 0);
    repeat (20) @(negedge clk);
    chk("rst_hold", {bus.ch_rd_en, bus.fmt_req, bus.fmt_chid, bus.fmt_length, bus.arb_busy}, 0);
    rst_n = 1'b1;
    drive_advance();
    step();
    chk("rst_first_req", {bus.fmt_req, bus.fmt_chid}, {1'b1, 2'd0});

    // Single channel, 4-word packet
    set_cfg(3'b001, 0, 0, 0, 2, 4, 8, 8);
    do_reset(2);
    clear_obs();
    repeat (12) step();
    chk("single_reads", rd_cnt[0], 4);
    chk("single_pkts", served.size(), 1);

    // Round-robin with equal priorities
    set_cfg(3'b111, 0, 0, 0, 1, 8, 8, 8);
    do_reset(2);
    clear_obs();
    repeat (17) step();
    chk("rr_count", served.size() >= 4, 1);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr_order%0d", k), k < served.size() ? served[k] : 99, rr_exp[k]);
    chk("rr_reads", rd_cnt[0] + rd_cnt[1] + rd_cnt[2], 8);

    // Priority: ch2 drains first, then ch0
    set_cfg(3'b111, 3, 3, 0, 1, 8, 8, 8);
    do_reset(2);
    clear_obs();
    repeat (22) step();
    for (int k = 0; k < 5; k++)
      chk($sformatf("prio_order%0d", k), k < served.size() ? served[k] : 99, pr_exp[k]);

    // Grant stall with pkt_len change while requesting
    set_cfg(3'b001, 0, 0, 0, 3, 8, 0, 0);
    grant_mode = 0;
    do_reset(2);
    clear_obs();
    repeat (6) step();
    cfg_len = 2'd0;
    repeat (5) step();
    chk("stall_no_rd", rd_cnt[0] + rd_cnt[1] + rd_cnt[2], 0);
    chk("stall_req", req_cnt, 11);
    grant_mode = 1;
    repeat (12) step();
    chk("stall_reads", rd_cnt[0], 8);

    // Slack beyond FIFO depth: ch0 never eligible
    set_cfg(3'b001, 0, 0, 0, 0, 8, 0, 0);
    ovr0 = 9;
    do_reset(2);
    clear_obs();
    repeat (20) step();
    chk("ovr_no_req", req_cnt, 0);
    ovr0 = 0;

    // Reset in the third read of a 4-word burst
    set_cfg(3'b111, 0, 0, 0, 2, 8, 8, 8);
    do_reset(2);
    found = 0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk);
      check_cycle();
      if (m_phase == 2 && m_cyc - m_g == 2) found = 1;
      else drive_advance();
    end
    chk("rst_mid_reached", found, 1);
    do_reset(3);
    clear_obs();
    repeat (6) step();
    chk("rst_mid_restart", req_cnt >= 1, 1);

    // Random traffic and configuration
    wr_pct = 30;
    grant_mode = 2;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(19) == 0) begin
        cfg_en = 3'($urandom_range(7));
        for (int i = 0; i < 3; i++) cfg_prio[i] = 2'($urandom_range(3));
        cfg_len = 2'($urandom_range(3));
        grant_mode = ($urandom_range(9) == 0) ? 0 : 2;
        ovr0 = ($urandom_range(7) == 0) ? 9 + int'($urandom_range(6)) : 0;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
